rx_frame_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receiver top.
- Captures each received byte on the receiver's data-valid indication, together with that frame's parity/stop error flags.
- Holds entries in a show-ahead FIFO so the host/bus side can drain bytes at its own pace with a valid/ready handshake.
- Reports fill level and a sticky overrun flag.

---
 rtl/uart_pkg.sv | 8 +
 rtl/rx_frame_fifo_if.sv | 40 ++++
 rtl/rx_vld_edge.sv | 15 +
 rtl/rx_frame_fifo.sv | 77 +++++++
 tb/tb_rx_frame_fifo.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-path constants and rx FIFO entry layout.
package uart_pkg;
    localparam int DATA_W      = 8;
    localparam int RX_DATA_LSB = 0;
    localparam int RX_PAR_BIT  = 8;
    localparam int RX_STP_BIT  = 9;
    localparam int RX_ENTRY_W  = DATA_W + 2;
endpackage

// File: rtl/rx_frame_fifo_if.sv
// rx_frame_fifo_if: receiver-side capture, host-side drain and status signals of the rx frame FIFO.
// ERR_DROP_CNT exists only when RX_FIFO_DROP_ERR_EN is defined.
interface rx_frame_fifo_if #(
    parameter int DATA_W = uart_pkg::DATA_W,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic [DATA_W-1:0] P_DATA;
    logic              DATA_VLD;
    logic              PAR_ERR;
    logic              STP_ERR;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_PAR_ERR;
    logic              RD_STP_ERR;
    logic              RD_VALID;
    logic              RD_READY;
    logic [CNT_W-1:0]  FIFO_CNT;
    logic              FULL;
    logic              OVERRUN;
    logic              CLR_OVR;
`ifdef RX_FIFO_DROP_ERR_EN
    logic [7:0]        ERR_DROP_CNT;
`endif

    modport master (
        output P_DATA, DATA_VLD, PAR_ERR, STP_ERR, RD_READY, CLR_OVR,
        input  RD_DATA, RD_PAR_ERR, RD_STP_ERR, RD_VALID, FIFO_CNT, FULL, OVERRUN
`ifdef RX_FIFO_DROP_ERR_EN
        , ERR_DROP_CNT
`endif
    );

    modport slave (
        input  P_DATA, DATA_VLD, PAR_ERR, STP_ERR, RD_READY, CLR_OVR,
        output RD_DATA, RD_PAR_ERR, RD_STP_ERR, RD_VALID, FIFO_CNT, FULL, OVERRUN
`ifdef RX_FIFO_DROP_ERR_EN
        , ERR_DROP_CNT
`endif
    );
endinterface

// File: rtl/rx_vld_edge.sv
// rx_vld_edge: turns the receiver's data-valid pulse or level into a single push strobe.
module rx_vld_edge (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    output logic push_req
);
    logic vld_d;

    always_ff @(posedge clk or posedge rst)
        if (rst) vld_d <= 1'b0;
        else     vld_d <= vld;

    assign push_req = vld & ~vld_d;
endmodule

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: show-ahead FIFO buffering received UART frames with their error flags.
// Optional RX_FIFO_DROP_ERR_EN discards errored frames and counts them on ERR_DROP_CNT.
module rx_frame_fifo #(
    parameter  int DATA_W = uart_pkg::DATA_W,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input logic            clk,
    input logic            ARST,
    rx_frame_fifo_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + 2;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               ovr, push_req, push_ok, full, empty, pop, wr_en, ovr_evt;

    rx_vld_edge u_edge (
        .clk      (clk),
        .rst      (ARST),
        .vld      (bus.DATA_VLD),
        .push_req (push_req)
    );

`ifdef RX_FIFO_DROP_ERR_EN
    logic       err_frame;
    logic [7:0] drop_cnt;

    assign err_frame = push_req & (bus.PAR_ERR | bus.STP_ERR);
    assign push_ok   = push_req & ~err_frame;

    // clear still records a discard arriving in the same cycle
    always_ff @(posedge clk or posedge ARST)
        if (ARST)             drop_cnt <= '0;
        else if (bus.CLR_OVR) drop_cnt <= 8'(err_frame);
        else if (err_frame && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

    assign bus.ERR_DROP_CNT = drop_cnt;
`else
    assign push_ok = push_req;
`endif

    assign full    = cnt == CNT_W'(DEPTH);
    assign empty   = cnt == '0;
    assign pop     = ~empty & bus.RD_READY;
    // a pop frees the slot in the same cycle, so a full FIFO can still accept
    assign wr_en   = push_ok & (~full | pop);
    assign ovr_evt = push_ok & full & ~pop;

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= {bus.STP_ERR, bus.PAR_ERR, bus.P_DATA};

    always_ff @(posedge clk or posedge ARST)
        if (ARST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_en);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            cnt    <= cnt + CNT_W'(wr_en) - CNT_W'(pop);
            ovr    <= ovr_evt ? 1'b1 : bus.CLR_OVR ? 1'b0 : ovr;
        end

    assign head           = empty ? '0 : mem[rd_ptr];
    assign bus.RD_DATA    = head[DATA_W-1:0];
    assign bus.RD_PAR_ERR = head[DATA_W];
    assign bus.RD_STP_ERR = head[DATA_W+1];
    assign bus.RD_VALID   = ~empty;
    assign bus.FIFO_CNT   = cnt;
    assign bus.FULL       = full;
    assign bus.OVERRUN    = ovr;
endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb_rx_frame_fifo: directed and randomized checks of rx_frame_fifo against a queue-based model.
// Builds with or without RX_FIFO_DROP_ERR_EN.
module tb_rx_frame_fifo;
    import uart_pkg::*;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    rx_frame_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    rx_frame_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .ARST (arst),
        .bus  (bus.slave)
    );

    logic [RX_ENTRY_W-1:0] q[$];
    logic vld_d_m, ovr_m;
`ifdef RX_FIFO_DROP_ERR_EN
    int drop_m;
`endif
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [RX_ENTRY_W-1:0] h;
        h = q.size() != 0 ? q[0] : '0;
        check("rd_valid", 32'(bus.RD_VALID), 32'(q.size() != 0));
        check("rd_data", 32'(bus.RD_DATA), 32'(h[RX_DATA_LSB +: DATA_W]));
        check("rd_par_err", 32'(bus.RD_PAR_ERR), 32'(h[RX_PAR_BIT]));
        check("rd_stp_err", 32'(bus.RD_STP_ERR), 32'(h[RX_STP_BIT]));
        check("fifo_cnt", 32'(bus.FIFO_CNT), 32'(q.size()));
        check("full", 32'(bus.FULL), 32'(q.size() == DEPTH));
        check("overrun", 32'(bus.OVERRUN), 32'(ovr_m));
`ifdef RX_FIFO_DROP_ERR_EN
        check("err_drop_cnt", 32'(bus.ERR_DROP_CNT), 32'(drop_m));
`endif
    endtask

    task automatic drive(logic v, logic [7:0] d, logic p, logic s, logic r, logic c);
        bus.DATA_VLD = v;
        bus.P_DATA   = d;
        bus.PAR_ERR  = p;
        bus.STP_ERR  = s;
        bus.RD_READY = r;
        bus.CLR_OVR  = c;
    endtask

    // one clock: predict from the inputs set before the edge, then compare at the falling edge
    task automatic cyc();
        logic [RX_ENTRY_W-1:0] e;
        bit push, pop, clr, ovr_evt;
`ifdef RX_FIFO_DROP_ERR_EN
        bit err_evt;
`endif
        push = bus.DATA_VLD && !vld_d_m;
        pop  = q.size() != 0 && bus.RD_READY;
        clr  = bus.CLR_OVR;
        ovr_evt = 1'b0;
        e = '0;
        e[RX_DATA_LSB +: DATA_W] = bus.P_DATA;
        e[RX_PAR_BIT] = bus.PAR_ERR;
        e[RX_STP_BIT] = bus.STP_ERR;
`ifdef RX_FIFO_DROP_ERR_EN
        err_evt = push && (bus.PAR_ERR || bus.STP_ERR);
        if (err_evt) push = 1'b0;
`endif
        vld_d_m = bus.DATA_VLD;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(e);
            else ovr_evt = 1'b1;
        end
        ovr_m = ovr_evt ? 1'b1 : clr ? 1'b0 : ovr_m;
`ifdef RX_FIFO_DROP_ERR_EN
        drop_m = clr ? int'(err_evt) : (err_evt && drop_m < 255) ? drop_m + 1 : drop_m;
`endif
        @(negedge clk);
        check_all();
    endtask

    task automatic push_frame(logic [7:0] d, logic p, logic s);
        drive(1'b1, d, p, s, 1'b0, 1'b0);
        cyc();
        drive(1'b0, d, p, s, 1'b0, 1'b0);
        cyc();
    endtask

    task automatic model_reset();
        q.delete();
        vld_d_m = 1'b0;
        ovr_m = 1'b0;
`ifdef RX_FIFO_DROP_ERR_EN
        drop_m = 0;
`endif
    endtask

    // called at a falling edge; reset asserts between edges and releases at the next falling edge
    task automatic do_reset();
        #2 arst = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("reset_valid", 32'(bus.RD_VALID), 32'd0);

        drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check("a5_valid", 32'(bus.RD_VALID), 32'd1);
        check("a5_data", 32'(bus.RD_DATA), 32'hA5);
        check("a5_cnt", 32'(bus.FIFO_CNT), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        check("a5_pop_valid", 32'(bus.RD_VALID), 32'd0);
        check("a5_pop_data", 32'(bus.RD_DATA), 32'd0);
        check("a5_pop_cnt", 32'(bus.FIFO_CNT), 32'd0);

        drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc();
        check("hold_cnt", 32'(bus.FIFO_CNT), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();

        for (int i = 0; i < 10; i++) push_frame(8'(i), 1'b0, 1'b0);
        check("ovf_cnt", 32'(bus.FIFO_CNT), 32'd8);
        check("ovf_full", 32'(bus.FULL), 32'd1);
        check("ovf_overrun", 32'(bus.OVERRUN), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", 32'(bus.RD_DATA), 32'(i));
            cyc();
        end
        check("drain_empty", 32'(bus.RD_VALID), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        check("clr_overrun", 32'(bus.OVERRUN), 32'd0);

        for (int i = 0; i < 8; i++) push_frame(8'(i), 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        check("fullpp_cnt", 32'(bus.FIFO_CNT), 32'd8);
        check("fullpp_overrun", 32'(bus.OVERRUN), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("fullpp_last", 32'(bus.RD_DATA), 32'h55);
            cyc();
        end

        push_frame(8'h11, 1'b1, 1'b0);
        push_frame(8'h22, 1'b0, 1'b1);
`ifdef RX_FIFO_DROP_ERR_EN
        check("errdrop_cnt", 32'(bus.FIFO_CNT), 32'd0);
        check("errdrop_num", 32'(bus.ERR_DROP_CNT), 32'd2);
`else
        check("err11_data", 32'(bus.RD_DATA), 32'h11);
        check("err11_par", 32'(bus.RD_PAR_ERR), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        check("err22_data", 32'(bus.RD_DATA), 32'h22);
        check("err22_stp", 32'(bus.RD_STP_ERR), 32'd1);
`endif
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc();

        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        push_frame(8'hA1, 1'b0, 1'b0);
        push_frame(8'hA2, 1'b0, 1'b0);
        push_frame(8'hA3, 1'b0, 1'b0);
        #2 bus.RD_READY = 1'b1;
        arst = 1'b1;
        model_reset();
        #1 check("arst_cnt", 32'(bus.FIFO_CNT), 32'd0);
        check("arst_valid", 32'(bus.RD_VALID), 32'd0);
        check("arst_overrun", 32'(bus.OVERRUN), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        push_frame(8'h77, 1'b0, 1'b0);
        check("arst_first", 32'(bus.RD_DATA), 32'h77);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();

        for (int k = 0; k < 3000; k++) begin
            int rdy_pct;
            rdy_pct = (k / 300) % 3 == 0 ? 10 : (k / 300) % 3 == 1 ? 50 : 90;
            drive(1'($urandom_range(0, 1)), 8'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 19) == 0);
            cyc();
            if (k % 1000 == 999) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
